// File: rtl/ps2_cmd_arbiter.sv
// ps2_cmd_arbiter: round-robin arbiter issuing PS/2 command bytes with ack, resend and timeout handling
module ps2_cmd_arbiter #(
  parameter int ACK_TIMEOUT = 5000000,
  parameter int MAX_RETRY = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       REQ0,
  input  logic       REQ1,
  input  logic [7:0] CMD0,
  input  logic [7:0] CMD1,
  output logic       DONE0,
  output logic       DONE1,
  output logic       ERR0,
  output logic       ERR1,
  output logic       SEND_BYTE,
  output logic [7:0] BYTE_TO_SEND,
  input  logic       BYTE_SENT,
  output logic       READ_ENABLE,
  input  logic       BYTE_READY,
  input  logic [7:0] BYTE_READ,
  input  logic [1:0] BYTE_ERROR_CODE,
  output logic       BUSY
);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam logic [TW-1:0] TLAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [RW-1:0] RMAX = RW'(MAX_RETRY);
  typedef enum logic [2:0] {IDLE, SEND, WAIT_SENT, WAIT_ACK, DONE, FAIL} state_t;
  state_t state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [7:0] byte_q, byte_d;
  logic idx_q, idx_d, last_q, last_d, rp;
  logic send_q, rd_q, busy_q, done0_q, done1_q, err0_q, err1_q;
  always_comb begin
    state_d = state_q;
    tmo_d = &tmo_q ? tmo_q : tmo_q + 1'b1;
    retry_d = retry_q;
    byte_d = byte_q;
    idx_d = idx_q;
    last_d = last_q;
    rp = 1'b0;
    case (state_q)
      IDLE: if (REQ0 | REQ1) begin
        idx_d = (REQ0 & REQ1) ? ~last_q : REQ1;
        last_d = idx_d;
        byte_d = idx_d ? CMD1 : CMD0;
        retry_d = '0;
        state_d = SEND;
      end
      SEND: begin
        tmo_d = '0;
        state_d = WAIT_SENT;
      end
      WAIT_SENT: if (BYTE_SENT) begin
        tmo_d = '0;
        state_d = WAIT_ACK;
      end else rp = tmo_q >= TLAST;
      // a reply in the timeout cycle still counts as a reply
      WAIT_ACK: if (BYTE_READY) begin
        if (BYTE_ERROR_CODE != 2'b00 || BYTE_READ == 8'hFE) rp = 1'b1;
        else state_d = (BYTE_READ == 8'hFA) ? DONE : FAIL;
      end else rp = tmo_q >= TLAST;
      default: state_d = IDLE;
    endcase
    if (rp) begin
      state_d = (retry_q < RMAX) ? SEND : FAIL;
      retry_d = (retry_q < RMAX) ? retry_q + 1'b1 : retry_q;
    end
    if (state_d == IDLE) byte_d = '0;
  end
  // outputs are registered from the next state so they line up with state_q
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      tmo_q <= '0;
      retry_q <= '0;
      byte_q <= '0;
      idx_q <= 1'b0;
      last_q <= 1'b1;
      send_q <= 1'b0;
      rd_q <= 1'b0;
      busy_q <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      err0_q <= 1'b0;
      err1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q <= tmo_d;
      retry_q <= retry_d;
      byte_q <= byte_d;
      idx_q <= idx_d;
      last_q <= last_d;
      send_q <= state_d == SEND;
      rd_q <= state_d == WAIT_ACK;
      busy_q <= state_d != IDLE;
      done0_q <= state_d == DONE && !idx_d;
      done1_q <= state_d == DONE && idx_d;
      err0_q <= state_d == FAIL && !idx_d;
      err1_q <= state_d == FAIL && idx_d;
    end
  end
  assign SEND_BYTE = send_q;
  assign BYTE_TO_SEND = byte_q;
  assign READ_ENABLE = rd_q;
  assign BUSY = busy_q;
  assign DONE0 = done0_q;
  assign DONE1 = done1_q;
  assign ERR0 = err0_q;
  assign ERR1 = err1_q;
endmodule

// File: tb/tb_ps2_cmd_arbiter.sv
// tb_ps2_cmd_arbiter: directed table, reset abort sequence and randomized transactions against a reference model
module tb_ps2_cmd_arbiter;
  localparam int AT = 100;
  localparam int MR = 2;
  localparam int KR = 0, KN = 1, KS = 2;
  logic CLK = 0, RESET = 1, REQ0 = 0, REQ1 = 0, BYTE_SENT = 0, BYTE_READY = 0;
  logic [7:0] CMD0 = 0, CMD1 = 0, BYTE_READ = 0;
  logic [1:0] BYTE_ERROR_CODE = 0;
  logic DONE0, DONE1, ERR0, ERR1, SEND_BYTE, READ_ENABLE, BUSY;
  logic [7:0] BYTE_TO_SEND;
  int nerr = 0, nchk = 0, exp_last = 1;
  int pk[3], psd[3], prd[3];
  logic [7:0] pb[3];
  logic [1:0] pe[3];
  bit noise = 0;
  typedef struct {
    logic [1:0] req;
    logic [7:0] c0, c1;
    int k0, k1, k2;
    logic [7:0] b0, b1, b2;
    logic [1:0] e0, e1, e2;
    int xi, xd, xs;
  } vec_t;
  vec_t vq[$];
  ps2_cmd_arbiter #(.ACK_TIMEOUT(AT), .MAX_RETRY(MR)) dut (
    .CLK(CLK), .RESET(RESET), .REQ0(REQ0), .REQ1(REQ1), .CMD0(CMD0), .CMD1(CMD1),
    .DONE0(DONE0), .DONE1(DONE1), .ERR0(ERR0), .ERR1(ERR1), .SEND_BYTE(SEND_BYTE),
    .BYTE_TO_SEND(BYTE_TO_SEND), .BYTE_SENT(BYTE_SENT), .READ_ENABLE(READ_ENABLE),
    .BYTE_READY(BYTE_READY), .BYTE_READ(BYTE_READ), .BYTE_ERROR_CODE(BYTE_ERROR_CODE), .BUSY(BUSY)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string name, input int got, input int exp);
    nchk++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask
  function automatic vec_t mk(logic [1:0] req, logic [7:0] c0, logic [7:0] c1,
      int k0, logic [7:0] b0, logic [1:0] e0, int k1, logic [7:0] b1, logic [1:0] e1,
      int k2, logic [7:0] b2, logic [1:0] e2, int xi, int xd, int xs);
    vec_t v;
    v.req = req; v.c0 = c0; v.c1 = c1;
    v.k0 = k0; v.b0 = b0; v.e0 = e0;
    v.k1 = k1; v.b1 = b1; v.e1 = e1;
    v.k2 = k2; v.b2 = b2; v.e2 = e2;
    v.xi = xi; v.xd = xd; v.xs = xs;
    return v;
  endfunction
  // outcome from the ack rules: FA done, FE/error code/silence resend, anything else fails
  task automatic predict(output int ok, output int n);
    ok = 0;
    n = MR + 1;
    for (int a = 0; a <= MR; a++) begin
      if (pk[a] == KR && pe[a] == 2'b00 && pb[a] != 8'hFE) begin
        ok = (pb[a] == 8'hFA) ? 1 : 0;
        n = a + 1;
        return;
      end
    end
  endtask
  task automatic serve(input int xi, input logic [7:0] xc, input int xd, input int xs, input bit drop);
    int sends = 0, a = 0, scd = 0, rcd = 0, gap = 0;
    bit fin = 0, timed = 0;
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      @(negedge CLK);
      BYTE_SENT = 0; BYTE_READY = 0; BYTE_READ = 0; BYTE_ERROR_CODE = 0;
      gap++;
      if (SEND_BYTE) begin
        if (timed) chk("resend_gap", gap, AT + 1);
        chk("send_byte_val", int'(BYTE_TO_SEND), int'(xc));
        chk("rd_en_in_send", int'(READ_ENABLE), 0);
        chk("busy_in_send", int'(BUSY), 1);
        a = sends; sends++; gap = 0; scd = psd[a]; rcd = 0; timed = 0;
        if (drop && sends == 1) begin
          if (xi == 0) REQ0 = 0; else REQ1 = 0;
        end
      end else if (scd > 0) begin
        scd--;
        if (scd == 0) begin
          timed = pk[a] != KR;
          if (pk[a] != KS) begin
            BYTE_SENT = 1; gap = 0; rcd = (pk[a] == KR) ? prd[a] : 0;
          end
        end else if (noise && $urandom_range(0, 3) == 0) begin
          BYTE_READY = 1; BYTE_READ = 8'hFA;
        end
      end else if (rcd > 0) begin
        rcd--;
        if (rcd == 0) begin
          chk("rd_en_at_reply", int'(READ_ENABLE), 1);
          BYTE_READY = 1; BYTE_READ = pb[a]; BYTE_ERROR_CODE = pe[a];
        end else if (noise && $urandom_range(0, 3) == 0) BYTE_SENT = 1;
      end
      if (DONE0 | DONE1 | ERR0 | ERR1) begin
        fin = 1;
        chk("result_onehot", $countones({DONE0, DONE1, ERR0, ERR1}), 1);
        chk("result_who", int'(DONE1 | ERR1), xi);
        chk("result_done", int'(DONE0 | DONE1), xd);
        if (xi == 0) REQ0 = 0; else REQ1 = 0;
      end
    end
    if (!fin) chk("result_timeout", 0, 1);
    chk("send_count", sends, xs);
    @(negedge CLK);
    BYTE_SENT = 0; BYTE_READY = 0; BYTE_READ = 0; BYTE_ERROR_CODE = 0;
    chk("pulse_one_cycle", $countones({DONE0, DONE1, ERR0, ERR1}), 0);
    chk("busy_after", int'(BUSY), 0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1);
  end
  initial begin
    int ok, n, win;
    vq.push_back(mk(2'b11, 8'hF4, 8'hF3, KR, 8'hFA, 0, KR, 8'hFA, 0, KR, 8'hFA, 0, 0, 1, 1));
    vq.push_back(mk(2'b10, 8'hF4, 8'hF3, KR, 8'hFA, 0, KR, 8'hFA, 0, KR, 8'hFA, 0, 1, 1, 1));
    vq.push_back(mk(2'b11, 8'hF4, 8'hF3, KR, 8'hFA, 0, KR, 8'hFA, 0, KR, 8'hFA, 0, 0, 1, 1));
    vq.push_back(mk(2'b11, 8'hF4, 8'hF3, KR, 8'hFA, 0, KR, 8'hFA, 0, KR, 8'hFA, 0, 1, 1, 1));
    vq.push_back(mk(2'b11, 8'hF4, 8'hF3, KR, 8'hFA, 0, KR, 8'hFA, 0, KR, 8'hFA, 0, 0, 1, 1));
    vq.push_back(mk(2'b01, 8'hF4, 8'h00, KR, 8'hFA, 0, KR, 8'hFA, 0, KR, 8'hFA, 0, 0, 1, 1));
    vq.push_back(mk(2'b01, 8'hF4, 8'h00, KR, 8'hFE, 0, KR, 8'hFE, 0, KR, 8'hFE, 0, 0, 0, 3));
    vq.push_back(mk(2'b01, 8'hF5, 8'h00, KN, 8'hFA, 0, KN, 8'hFA, 0, KN, 8'hFA, 0, 0, 0, 3));
    vq.push_back(mk(2'b10, 8'h00, 8'hF6, KN, 8'hFA, 0, KR, 8'hFA, 0, KR, 8'hFA, 0, 1, 1, 2));
    vq.push_back(mk(2'b01, 8'hED, 8'h00, KR, 8'hFA, 1, KR, 8'hFA, 0, KR, 8'hFA, 0, 0, 1, 2));
    vq.push_back(mk(2'b10, 8'h00, 8'hF2, KR, 8'hFC, 0, KR, 8'hFA, 0, KR, 8'hFA, 0, 1, 0, 1));
    vq.push_back(mk(2'b01, 8'hF0, 8'h00, KS, 8'hFA, 0, KR, 8'hFE, 0, KR, 8'hFA, 0, 0, 1, 3));
    vq.push_back(mk(2'b10, 8'h00, 8'hFF, KR, 8'h00, 0, KR, 8'hFA, 0, KR, 8'hFA, 0, 1, 0, 1));
    repeat (3) @(negedge CLK);
    chk("reset_outputs", int'({SEND_BYTE, READ_ENABLE, BUSY, DONE0, DONE1, ERR0, ERR1, BYTE_TO_SEND}), 0);
    RESET = 0;
    @(negedge CLK);
    chk("idle_outputs", int'({SEND_BYTE, READ_ENABLE, BUSY, DONE0, DONE1, ERR0, ERR1, BYTE_TO_SEND}), 0);
    foreach (vq[i]) begin
      REQ0 = vq[i].req[0]; REQ1 = vq[i].req[1]; CMD0 = vq[i].c0; CMD1 = vq[i].c1;
      pk[0] = vq[i].k0; pk[1] = vq[i].k1; pk[2] = vq[i].k2;
      pb[0] = vq[i].b0; pb[1] = vq[i].b1; pb[2] = vq[i].b2;
      pe[0] = vq[i].e0; pe[1] = vq[i].e1; pe[2] = vq[i].e2;
      for (int a = 0; a < 3; a++) begin psd[a] = 10; prd[a] = 3; end
      serve(vq[i].xi, vq[i].xi != 0 ? vq[i].c1 : vq[i].c0, vq[i].xd, vq[i].xs, 0);
      exp_last = vq[i].xi;
    end
    // reset while waiting for the ack: abort silently, then serve the still-pending requester
    REQ0 = 0; REQ1 = 1; CMD1 = 8'hE8;
    n = 0;
    for (int c = 0; c < 20 && !SEND_BYTE; c++) @(negedge CLK);
    chk("rst_seq_send", int'(SEND_BYTE), 1);
    chk("rst_seq_byte", int'(BYTE_TO_SEND), 8'hE8);
    repeat (3) @(negedge CLK);
    BYTE_SENT = 1;
    @(negedge CLK);
    BYTE_SENT = 0;
    @(negedge CLK);
    chk("rst_seq_wait_ack", int'(READ_ENABLE), 1);
    #2 RESET = 1;
    #1 chk("rst_async_clear", int'({SEND_BYTE, READ_ENABLE, BUSY, DONE0, DONE1, ERR0, ERR1, BYTE_TO_SEND}), 0);
    repeat (2) begin
      @(negedge CLK);
      chk("rst_no_result", $countones({DONE0, DONE1, ERR0, ERR1}), 0);
    end
    RESET = 0;
    exp_last = 1;
    pk[0] = KR; pb[0] = 8'hFA; pe[0] = 0; psd[0] = 4; prd[0] = 2;
    serve(1, 8'hE8, 1, 1, 0);
    exp_last = 1;
    noise = 1;
    for (int t = 0; t < 30; t++) begin
      if (!REQ0 && $urandom_range(0, 1) == 1) begin REQ0 = 1; CMD0 = 8'($urandom); end
      if (!REQ1 && $urandom_range(0, 1) == 1) begin REQ1 = 1; CMD1 = 8'($urandom); end
      if (!REQ0 && !REQ1) begin REQ0 = 1; CMD0 = 8'($urandom); end
      win = (REQ0 && REQ1) ? 1 - exp_last : (REQ1 ? 1 : 0);
      for (int a = 0; a < 3; a++) begin
        n = $urandom_range(0, 9);
        pk[a] = n < 7 ? KR : (n < 9 ? KN : KS);
        n = $urandom_range(0, 9);
        pb[a] = n < 5 ? 8'hFA : (n < 8 ? 8'hFE : (n == 8 ? 8'hFC : 8'($urandom)));
        pe[a] = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        psd[a] = $urandom_range(1, 20);
        prd[a] = $urandom_range(1, 20);
      end
      predict(ok, n);
      serve(win, win != 0 ? CMD1 : CMD0, ok, n, $urandom_range(0, 3) == 0);
      exp_last = win;
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
